// File: rtl/noc_pkg.sv
// Shared NoC flit definitions for the tree-internal merge and decode leaves.
package noc_pkg;

  localparam int unsigned FLIT_W   = 9;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned ADDR_LSB = 5;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic              src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers the previous winner so ties alternate.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr_last;

  // Single requester wins outright; a tie goes to the input that did not win last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset to 1 so input 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (en && (|gnt)) begin
      rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/merge2_rr_arb.sv
// Two-input flit merge: 1-entry buffer per input, round-robin pick, registered output with source index.
module merge2_rr_arb
  import noc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [FLIT_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [FLIT_W-1:0] in1_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_data,
  output logic              out_src,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic [1:0] buf_full;
  logic [1:0] full_nxt;
  logic [1:0] hs;
  logic [1:0] gnt;
  logic       ld;
  flit_t      buf0_data;
  flit_t      buf1_data;

  assign hs       = {in1_valid && in1_ready, in0_valid && in0_ready};
  assign ld       = !out_valid || out_ready;
  // A buffer granted this edge empties; a handshake can only land in an empty one.
  assign full_nxt = (buf_full & ~gnt) | hs;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (buf_full),
    .en    (ld),
    .gnt   (gnt)
  );

  // Ready is a flop of the next-cycle emptiness, so it is low during reset and never sees out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full  <= 2'b00;
      in0_ready <= 1'b0;
      in1_ready <= 1'b0;
    end else begin
      buf_full  <= full_nxt;
      in0_ready <= !full_nxt[0];
      in1_ready <= !full_nxt[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_data <= '0;
      buf1_data <= '0;
    end else begin
      if (hs[0]) buf0_data <= in0_data;
      if (hs[1]) buf1_data <= in1_data;
    end
  end

  // Output stage: reload whenever empty or being consumed; hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (ld) begin
      if (|gnt) begin
        out_valid <= 1'b1;
        out_data  <= gnt[1] ? buf1_data : buf0_data;
        out_src   <= gnt[1];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (hs[0]) cnt0 <= cnt0 + CNT_W'(1);
      if (hs[1]) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_merge2_rr_arb.sv
// Bench for merge2_rr_arb: directed cycle table, reset/wrap sequences, randomized scoreboard run.
module tb_merge2_rr_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in0_ready, in1_valid, in1_ready;
  logic [8:0] in0_data, in1_data, out_data;
  logic       out_valid, out_ready, out_src;
  logic [15:0] cnt0, cnt1;

  logic       w_in0_valid, w_in0_ready, w_in1_valid, w_in1_ready;
  logic [8:0] w_in0_data, w_in1_data, w_out_data;
  logic       w_out_valid, w_out_ready, w_out_src;
  logic [7:0] w_cnt0, w_cnt1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  merge2_rr_arb dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .cnt0(cnt0), .cnt1(cnt1)
  );

  // Narrow-counter copy so the wrap is reachable in a short run.
  merge2_rr_arb #(.CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(w_in0_valid), .in0_ready(w_in0_ready), .in0_data(w_in0_data),
    .in1_valid(w_in1_valid), .in1_ready(w_in1_ready), .in1_data(w_in1_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_src(w_out_src), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  typedef struct {
    logic       i0v;
    logic [8:0] i0d;
    logic       i1v;
    logic [8:0] i1d;
    logic       ordy;
    logic       ev;
    logic [8:0] ed;
    logic       es;
    logic       er0;
    logic       er1;
    logic [15:0] ec0;
    logic [15:0] ec1;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic i0v, logic [8:0] i0d, logic i1v, logic [8:0] i1d,
                              logic ordy, logic ev, logic [8:0] ed, logic es,
                              logic er0, logic er1, logic [15:0] ec0, logic [15:0] ec1);
    vec_t v;
    v.i0v = i0v; v.i0d = i0d; v.i1v = i1v; v.i1d = i1d; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.es = es; v.er0 = er0; v.er1 = er1; v.ec0 = ec0; v.ec1 = ec1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic idle_inputs();
    in0_valid = 1'b0; in0_data = '0; in1_valid = 1'b0; in1_data = '0;
    w_in0_valid = 1'b0; w_in0_data = '0; w_in1_valid = 1'b0; w_in1_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [8:0] ed, input logic es,
                            input logic er0, input logic er1, input logic [15:0] ec0, input logic [15:0] ec1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out_data"},  32'(out_data),  32'(ed));
    chk({tag, ".out_src"},   32'(out_src),   32'(es));
    chk({tag, ".ready"},     32'({in1_ready, in0_ready}), 32'({er1, er0}));
    chk({tag, ".cnt"},       32'({cnt1, cnt0}), {ec1, ec0});
  endtask

  // Scoreboard state for the random phase
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int unsigned mc0, mc1;

  initial begin
    // in0v in0d  in1v in1d  ordy | ev  data  src rdy0 rdy1 cnt0 cnt1
    tbl[0]  = mk(0, 9'h000, 0, 9'h000, 1,  0, 9'h000, 0, 1, 1, 0, 0);
    tbl[1]  = mk(1, 9'h1A1, 1, 9'h0C3, 1,  0, 9'h000, 0, 0, 0, 1, 1);
    tbl[2]  = mk(0, 9'h000, 0, 9'h000, 1,  1, 9'h1A1, 0, 1, 0, 1, 1);
    tbl[3]  = mk(0, 9'h000, 0, 9'h000, 1,  1, 9'h0C3, 1, 1, 1, 1, 1);
    tbl[4]  = mk(0, 9'h000, 0, 9'h000, 1,  0, 9'h0C3, 1, 1, 1, 1, 1);
    tbl[5]  = mk(1, 9'h155, 0, 9'h000, 1,  0, 9'h0C3, 1, 0, 1, 2, 1);
    tbl[6]  = mk(0, 9'h000, 0, 9'h000, 1,  1, 9'h155, 0, 1, 1, 2, 1);
    tbl[7]  = mk(0, 9'h000, 0, 9'h000, 1,  0, 9'h155, 0, 1, 1, 2, 1);
    tbl[8]  = mk(1, 9'h011, 1, 9'h022, 1,  0, 9'h155, 0, 0, 0, 3, 2);
    tbl[9]  = mk(0, 9'h000, 0, 9'h000, 1,  1, 9'h022, 1, 0, 1, 3, 2);
    tbl[10] = mk(0, 9'h000, 0, 9'h000, 1,  1, 9'h011, 0, 1, 1, 3, 2);
    tbl[11] = mk(0, 9'h000, 0, 9'h000, 1,  0, 9'h011, 0, 1, 1, 3, 2);
    tbl[12] = mk(1, 9'h033, 1, 9'h044, 0,  0, 9'h011, 0, 0, 0, 4, 3);
    tbl[13] = mk(0, 9'h000, 0, 9'h000, 0,  1, 9'h044, 1, 0, 1, 4, 3);
    tbl[14] = mk(0, 9'h000, 1, 9'h055, 0,  1, 9'h044, 1, 0, 0, 4, 4);
    for (int i = 15; i < 19; i++)
      tbl[i] = mk(0, 9'h000, 0, 9'h000, 0, 1, 9'h044, 1, 0, 0, 4, 4);
    tbl[19] = mk(0, 9'h000, 0, 9'h000, 1,  1, 9'h033, 0, 1, 0, 4, 4);
    tbl[20] = mk(0, 9'h000, 0, 9'h000, 1,  1, 9'h055, 1, 1, 1, 4, 4);
    tbl[21] = mk(0, 9'h000, 0, 9'h000, 1,  0, 9'h055, 1, 1, 1, 4, 4);

    rst_n = 1'b0;
    out_ready = 1'b0;
    w_out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 9'h000, 0, 0, 0, 0, 0);

    // Directed cycle table
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      in0_valid = tbl[i].i0v; in0_data = tbl[i].i0d;
      in1_valid = tbl[i].i1v; in1_data = tbl[i].i1d;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      check_outs($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].es,
                 tbl[i].er0, tbl[i].er1, tbl[i].ec0, tbl[i].ec1);
    end

    // Mid-stream async reset: discards everything and restores the input-0 tie preference
    in0_valid = 1'b1; in0_data = 9'h0AA; in1_valid = 1'b1; in1_data = 9'h0BB; out_ready = 1'b0;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    chk("pre_rst.out_valid", 32'(out_valid), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("in_rst.out_valid", 32'(out_valid), 32'(0));
    chk("in_rst.ready", 32'({in1_ready, in0_ready}), 32'(0));
    chk("in_rst.cnt", 32'({cnt1, cnt0}), 32'(0));
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_outs("post_rst", 0, 9'h000, 0, 1, 1, 0, 0);
    in0_valid = 1'b1; in0_data = 9'h0CC; in1_valid = 1'b1; in1_data = 9'h0DD;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check_outs("post_rst_g0", 1, 9'h0CC, 0, 1, 0, 1, 1);
    @(negedge clk);
    check_outs("post_rst_g1", 1, 9'h0DD, 1, 1, 1, 1, 1);

    // Randomized traffic against a queue scoreboard
    do_reset();
    q0.delete(); q1.delete();
    mc0 = 0; mc1 = 0;
    begin
      logic hold0, hold1, stall_prev;
      logic [10:0] prev_out;
      hold0 = 1'b0; hold1 = 1'b0; stall_prev = 1'b0; prev_out = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (stall_prev)
          chk("stall_hold", 32'({out_valid, out_src, out_data}), 32'(prev_out));
        if (!hold0) begin
          in0_valid = ($urandom_range(0, 2) != 0);
          in0_data  = 9'($urandom_range(0, 511));
        end
        if (!hold1) begin
          in1_valid = ($urandom_range(0, 2) != 0);
          in1_data  = 9'($urandom_range(0, 511));
        end
        out_ready = (cyc >= 2980) ? 1'b1 : ($urandom_range(0, 9) < 7);
        if (cyc >= 2980) begin
          in0_valid = 1'b0; in1_valid = 1'b0;
        end
        chk("rnd.cnt0", 32'(cnt0), 32'(mc0[15:0]));
        chk("rnd.cnt1", 32'(cnt1), 32'(mc1[15:0]));
        if (in0_valid && in0_ready) begin q0.push_back(in0_data); mc0++; end
        if (in1_valid && in1_ready) begin q1.push_back(in1_data); mc1++; end
        if (out_valid && out_ready) begin
          if (out_src == 1'b0) begin
            if (q0.size() == 0) fail_now("rnd.spurious_src0");
            else chk("rnd.order_src0", 32'(out_data), 32'(q0.pop_front()));
          end else begin
            if (q1.size() == 0) fail_now("rnd.spurious_src1");
            else chk("rnd.order_src1", 32'(out_data), 32'(q1.pop_front()));
          end
        end
        hold0 = in0_valid && !in0_ready;
        hold1 = in1_valid && !in1_ready;
        stall_prev = out_valid && !out_ready;
        prev_out = {out_valid, out_src, out_data};
        @(negedge clk);
      end
      chk("rnd.drain0", 32'(q0.size()), 32'(0));
      chk("rnd.drain1", 32'(q1.size()), 32'(0));
      chk("rnd.idle", 32'(out_valid), 32'(0));
    end

    // Counter wrap on the 8-bit copy
    do_reset();
    begin
      int acc;
      acc = 0;
      w_in0_data = 9'h0F0;
      for (int c = 0; c < 2000 && acc < 255; c++) begin
        w_in0_valid = 1'b1;
        if (w_in0_ready) acc++;
        @(negedge clk);
      end
      w_in0_valid = 1'b0;
      chk("wrap.accepts", 32'(acc), 32'(255));
      @(negedge clk);
      chk("wrap.full_count", 32'(w_cnt0), 32'(255));
      acc = 0;
      for (int c = 0; c < 20 && acc < 1; c++) begin
        w_in0_valid = 1'b1;
        if (w_in0_ready) acc++;
        @(negedge clk);
      end
      w_in0_valid = 1'b0;
      chk("wrap.last_accept", 32'(acc), 32'(1));
      chk("wrap.cnt0", 32'(w_cnt0), 32'(0));
      chk("wrap.cnt1", 32'(w_cnt1), 32'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/merge2_rr_arb.md
Name: merge2_rr_arb

Overview:
- Two-input flit merge: the opposite direction of the one-to-two decoder leaf. It collects 9-bit flits from two upstream channels and serialises them onto one downstream channel.
- Sideband `out_src` carries the winning input index, the counterpart of the decoder's select token S.
- Sits at tree-internal merge points of the NoC.
- Clocked block with valid/ready handshakes, per-input 1-entry buffers, round-robin arbitration and a registered output stage.

Parameters:
- FLIT_W, 9: flit width; [8:5] is the destination address, [4:0] is the payload.
- ADDR_W, 4: address field width, located at the MSBs of the flit.
- CNT_W, 16: width of the per-input accepted-flit counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in0_valid  in  1  input 0 flit valid.
- in0_ready  out  1  input 0 can accept.
- in0_data  in  FLIT_W  input 0 flit.
- in1_valid  in  1  input 1 flit valid.
- in1_ready  out  1  input 1 can accept.
- in1_data  in  FLIT_W  input 1 flit.
- out_valid  out  1  merged flit valid.
- out_ready  in  1  downstream accepts.
- out_data  out  FLIT_W  merged flit.
- out_src  out  1  source of out_data: 0 = in0, 1 = in1.
- cnt0  out  CNT_W  flits accepted on in0 since reset.
- cnt1  out  CNT_W  flits accepted on in1 since reset.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - buf0/buf1 empty; output register empty.
  - out_valid=0, out_data=0, out_src=0.
  - cnt0=cnt1=0.
  - rr_last=1, so input 0 wins the first tie.
  - in*_ready=0 while rst_n=0.
- Reset mid-operation: all buffered and output flits are discarded, with no partial transfer.
- Handshake: a transfer occurs on the rising edge where valid && ready.
  - Each upstream holds data stable while valid && !ready.
- Input buffers: inK_ready = !bufK_full, registered with no combinational path from out_ready.
  - A handshake on inK loads bufK and increments cntK, wrapping modulo 2^CNT_W.
- Output register load enable: ld = !out_valid || out_ready.
- Arbitration, evaluated each cycle when ld=1:
  - Only buf0 full: grant 0.
  - Only buf1 full: grant 1.
  - Both full: grant !rr_last.
  - Neither full: no grant; out_valid goes 0 after the edge if the current flit was consumed.
- On a grant at an edge:
  - The output register takes {bufG, G}, out_valid=1.
  - bufG is freed and rr_last=G.
  - A buffer being granted at the same edge cannot also accept input, because ready=0 while it is full.
- Stall: while out_valid && !out_ready, out_data, out_src and out_valid hold stable, and no grant is made.
- Latency: an input handshake at edge E0 gives out_valid at the earliest after E1, when the output is free.
- Throughput:
  - The output can sustain 1 flit/cycle when both inputs are loaded.
  - A single input sustains 1 flit per 2 cycles, because the buffer frees at E1 and ready reasserts after E1.
- Ordering: flits from one input leave in arrival order. No flit is dropped or duplicated.
- Fairness: under continuous contention the grants strictly alternate 0,1,0,1.
- The flit is not modified; address bits [8:5] pass through untouched.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W, ADDR_W.
  - ADDR_LSB=5.
  - Typedef flit_t (logic [FLIT_W-1:0]).
  - Typedef src_t (logic).
- One sub-module, rr_arb2:
  - Inputs req[1:0], en; output gnt[1:0] (one-hot or zero).
  - Owns the rr_last flop, which updates only when en && |gnt.

Test Plan:
- Reset then a single flit in0=9'h155 with out_ready=1 -> out_valid after 2 edges, out_data=9'h155, out_src=0, cnt0=1, cnt1=0.
- in0=9'h1A1 and in1=9'h0C3 accepted on the same edge, out_ready=1 -> 9'h1A1/src0, then 9'h0C3/src1 on consecutive cycles; rr_last=1 afterwards.
- Both inputs streaming continuously (in0: 0x100..0x107, in1: 0x080..0x087) -> sources alternate 0,1,0,...; each stream's order is preserved; cnt0=cnt1=8.
- out_ready=0 for 5 cycles with both buffers full -> out_data stable, in0_ready=in1_ready=0, no counter change; releasing gives the pending flits in RR order.
- rst_n pulsed low for 3 ns mid-stream with out_valid=1 -> out_valid drops to 0 asynchronously; after release the first grant goes to input 0 and the counters read 0.
- cnt0 preloaded by 65535 accepts then one more -> cnt0 wraps to 0.
